// File: rtl/uart_rx_pkg.sv
// Shared types and default widths for the uart_rx blocks.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing FSM for the UART receiver: steps START/DATA/PARITY/STOP, strobes the
// checkers and deserializer, and reports each finished frame with a one-cycle pulse.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [BIT_CNT_W-1:0]  bit_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_enable,
  output logic                  data_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  busy,
  output logic                  data_valid,
  output logic                  par_err_o,
  output logic                  stp_err_o
);
  import uart_rx_pkg::*;

  rx_state_e state_q, state_d;
  logic      p_flag_q, p_flag_d;
  logic      s_flag_q, s_flag_d;
  logic      last_edge;
  logic      last_data_bit;
  logic      in_frame;

  assign last_edge     = (edge_cnt == (prescale - PRESCALE_W'(1)));
  assign last_data_bit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

  always_comb begin
    state_d  = state_q;
    p_flag_d = p_flag_q;
    s_flag_d = s_flag_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_in) state_d = StStart;
      end
      StStart: begin
        if (last_edge) state_d = strt_glitch ? StIdle : StData;
      end
      StData: begin
        if (last_edge && last_data_bit) state_d = par_en ? StParity : StStop;
      end
      StParity: begin
        if (last_edge) begin
          p_flag_d = p_flag_q | par_err;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (last_edge) begin
          s_flag_d = s_flag_q | stp_err;
          state_d  = StDone;
        end
      end
      StDone: begin
        p_flag_d = 1'b0;
        s_flag_d = 1'b0;
        // A low line here is the next start bit; skip IDLE so the counter stays aligned.
        state_d  = rx_in ? StIdle : StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      p_flag_q <= 1'b0;
      s_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_flag_q <= p_flag_d;
      s_flag_q <= s_flag_d;
    end
  end

  assign in_frame = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);

  always_comb begin
    cnt_enable   = in_frame;
    data_samp_en = in_frame;
    busy         = in_frame;
    strt_chk_en  = (state_q == StStart) && last_edge;
    par_chk_en   = (state_q == StParity) && last_edge;
    stp_chk_en   = (state_q == StStop) && last_edge;
    deser_en     = (state_q == StData) && last_edge && (bit_cnt != '0) &&
                   (bit_cnt <= BIT_CNT_W'(DATA_WIDTH));
    data_valid   = (state_q == StDone) && !p_flag_q && !s_flag_q;
    par_err_o    = (state_q == StDone) && p_flag_q;
    stp_err_o    = (state_q == StDone) && s_flag_q;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: models the edge/bit counter, drives frames cycle by cycle
// and checks strobe timing, decoded bytes and the frame-result pulses.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic [PW-1:0] prescale;
  logic [PW-1:0] edge_cnt = '0;
  logic [BW-1:0] bit_cnt = '0;
  logic          strt_glitch, par_err, stp_err;
  logic          cnt_enable, data_samp_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          deser_en, busy, data_valid, par_err_o, stp_err_o;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW),
    .BIT_CNT_W (BW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .cnt_enable  (cnt_enable),
    .data_samp_en(data_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .busy        (busy),
    .data_valid  (data_valid),
    .par_err_o   (par_err_o),
    .stp_err_o   (stp_err_o)
  );

  // Neighbouring edge/bit counter: cleared whenever its enable is low.
  always @(posedge clk) begin
    if (rst || !cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale - 1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Configuration must hold while a frame is in progress.
  logic          busy_prev = 1'b0;
  logic          par_en_prev = 1'b0;
  logic [PW-1:0] prescale_prev = '0;
  always @(posedge clk) begin
    if (busy && busy_prev)
      assert (par_en == par_en_prev && prescale == prescale_prev)
        else $error("configuration changed mid-frame");
    busy_prev     <= busy;
    par_en_prev   <= par_en;
    prescale_prev <= prescale;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int         r_deser_n, r_deser_first, r_deser_last;
  int         r_strt_t, r_par_t, r_par_n, r_stp_t, r_stp_n;
  int         r_dv_t, r_dv_n, r_pe_t, r_pe_n, r_se_t, r_se_n;
  int         r_busy_first, r_busy_last, r_busy_n;
  int         r_edge1, r_busy1;
  int         r_excl = 0;
  logic [7:0] r_byte;
  logic [9:0] r_rst_out;

  function automatic logic rx_val(int t, int p, bit pen, logic [7:0] d, bit glitch,
                                  bit chain_out, int rst_at);
    int k;
    int tdone;
    tdone = 1 + p * (10 + int'(pen));
    if (t == 0) return 1'b0;
    if (glitch) return 1'b1;
    if (rst_at >= 0 && t > rst_at) return 1'b1;
    if (t == tdone && chain_out) return 1'b0;
    k = (t - 1) / p;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (pen && k == 9) return ^d;
    return 1'b1;
  endfunction

  // t=0 is the IDLE cycle with rx_in low; chain_in means that cycle was the previous DONE.
  task automatic run_frame(input int p, input bit pen, input logic [7:0] d, input bit glitch,
                           input bit perr, input bit serr, input bit chain_in,
                           input bit chain_out, input int rst_at, input int tlen);
    r_deser_n = 0; r_deser_first = -1; r_deser_last = -1;
    r_strt_t = -1; r_par_t = -1; r_par_n = 0; r_stp_t = -1; r_stp_n = 0;
    r_dv_t = -1; r_dv_n = 0; r_pe_t = -1; r_pe_n = 0; r_se_t = -1; r_se_n = 0;
    r_busy_first = -1; r_busy_last = -1; r_busy_n = 0;
    r_edge1 = -1; r_busy1 = -1; r_byte = '0; r_rst_out = '1;
    for (int t = (chain_in ? 1 : 0); t <= tlen; t++) begin
      @(posedge clk);
      #1;
      prescale    = PW'(p);
      par_en      = pen;
      strt_glitch = glitch;
      par_err     = perr;
      stp_err     = serr;
      rst         = (t == rst_at);
      rx_in       = rx_val(t, p, pen, d, glitch, chain_out, rst_at);
      @(negedge clk);
      if (deser_en) begin
        r_deser_n++;
        if (r_deser_first < 0) r_deser_first = t;
        r_deser_last = t;
        r_byte = {rx_in, r_byte[7:1]};
      end
      if (strt_chk_en) r_strt_t = t;
      if (par_chk_en) begin r_par_n++; r_par_t = t; end
      if (stp_chk_en) begin r_stp_n++; r_stp_t = t; end
      if (data_valid) begin r_dv_n++; r_dv_t = t; end
      if (par_err_o) begin r_pe_n++; r_pe_t = t; end
      if (stp_err_o) begin r_se_n++; r_se_t = t; end
      if (busy) begin
        r_busy_n++;
        if (r_busy_first < 0) r_busy_first = t;
        r_busy_last = t;
      end
      if (int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en) > 1) r_excl++;
      if (t == 1) begin r_edge1 = int'(edge_cnt); r_busy1 = int'(busy); end
      if (t == rst_at + 1)
        r_rst_out = {cnt_enable, data_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                     deser_en, busy, data_valid, par_err_o, stp_err_o};
    end
    rst = 1'b0;
    if (!chain_out) rx_in = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b1; prescale = PW'(8);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {cnt_enable, data_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                            deser_en, busy, data_valid, par_err_o, stp_err_o}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Clean frame, parity on.
    run_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, -1, 92);
    check("p1_deser_n", r_deser_n, 8);
    check("p1_deser_first", r_deser_first, 16);
    check("p1_deser_last", r_deser_last, 72);
    check("p1_strt_t", r_strt_t, 8);
    check("p1_par_t", r_par_t, 80);
    check("p1_par_n", r_par_n, 1);
    check("p1_stp_t", r_stp_t, 88);
    check("p1_dv_t", r_dv_t, 89);
    check("p1_dv_n", r_dv_n, 1);
    check("p1_busy_first", r_busy_first, 1);
    check("p1_busy_last", r_busy_last, 88);
    check("p1_busy_n", r_busy_n, 88);
    check("p1_byte", r_byte, 8'hA5);
    check("p1_err_pulses", r_pe_n + r_se_n, 0);

    // Parity off: one bit period shorter.
    run_frame(8, 0, 8'hA5, 0, 0, 0, 0, 0, -1, 84);
    check("np_par_n", r_par_n, 0);
    check("np_stp_t", r_stp_t, 80);
    check("np_dv_t", r_dv_t, 81);
    check("np_busy_last", r_busy_last, 80);
    check("np_byte", r_byte, 8'hA5);

    // Start-bit glitch.
    run_frame(8, 1, 8'h00, 1, 0, 0, 0, 0, -1, 20);
    check("gl_strt_t", r_strt_t, 8);
    check("gl_busy_last", r_busy_last, 8);
    check("gl_busy_n", r_busy_n, 8);
    check("gl_deser_n", r_deser_n, 0);
    check("gl_pulses", r_dv_n + r_pe_n + r_se_n, 0);
    strt_glitch = 1'b0;

    // Parity error, then stop error.
    run_frame(8, 1, 8'hA5, 0, 1, 0, 0, 0, -1, 92);
    check("pe_pe_t", r_pe_t, 89);
    check("pe_pe_n", r_pe_n, 1);
    check("pe_dv_n", r_dv_n, 0);
    check("pe_se_n", r_se_n, 0);
    run_frame(8, 1, 8'hA5, 0, 0, 1, 0, 0, -1, 92);
    check("se_se_t", r_se_t, 89);
    check("se_se_n", r_se_n, 1);
    check("se_dv_n", r_dv_n, 0);
    check("se_pe_n", r_pe_n, 0);
    par_err = 1'b0; stp_err = 1'b0;

    // Back-to-back frames: the second start bit begins in the DONE cycle.
    run_frame(8, 1, 8'hA5, 0, 0, 0, 0, 1, -1, 89);
    check("bb1_dv_t", r_dv_t, 89);
    check("bb1_byte", r_byte, 8'hA5);
    run_frame(8, 1, 8'h3C, 0, 0, 0, 1, 0, -1, 92);
    check("bb2_edge1", r_edge1, 0);
    check("bb2_busy1", r_busy1, 1);
    check("bb2_byte", r_byte, 8'h3C);
    check("bb2_dv_t", r_dv_t, 89);
    check("bb2_dv_n", r_dv_n, 1);

    // Reset mid-DATA aborts the frame silently.
    run_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, 40, 100);
    check("rs_outputs", r_rst_out, 0);
    check("rs_busy_last", r_busy_last, 40);
    check("rs_pulses", r_dv_n + r_pe_n + r_se_n, 0);
    run_frame(8, 1, 8'h5A, 0, 0, 0, 0, 0, -1, 92);
    check("rs2_byte", r_byte, 8'h5A);
    check("rs2_dv_t", r_dv_t, 89);

    // Prescale extremes.
    run_frame(4, 0, 8'h81, 0, 0, 0, 0, 0, -1, 44);
    check("p4_deser_first", r_deser_first, 8);
    check("p4_deser_last", r_deser_last, 36);
    check("p4_stp_t", r_stp_t, 40);
    check("p4_dv_t", r_dv_t, 41);
    check("p4_byte", r_byte, 8'h81);
    run_frame(32, 1, 8'hFF, 0, 0, 0, 0, 0, -1, 356);
    check("p32_par_t", r_par_t, 320);
    check("p32_dv_t", r_dv_t, 353);
    check("p32_byte", r_byte, 8'hFF);

    check("strobe_exclusive", r_excl, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
